// File: rtl/usr_pkg.sv
// usr_pkg: shared types for the serial transfer sequencer and its shift register.
// Contents: FSM state enum, shift register mode encodings, default register width.
// Latency/backpressure: not applicable (types and constants only).
package usr_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_reg_core.sv
// shift_reg_core: WIDTH-bit universal shift register (hold, shift right, shift left, parallel load).
// Latency: q_o reflects the selected operation one clock after mode_i/d_i are presented.
// Backpressure: none; the register acts on mode_i every cycle.
// Ports: clk_i/rst_i (sync active-high, clears q), mode_i, d_i (load word),
//        sin_left_i (enters MSB on SHR), sin_right_i (enters LSB on SHL), q_o (register contents).
module shift_reg_core
  import usr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_left_i,
  input  logic             sin_right_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (mode_i)
      SHR:     q_d = {sin_left_i, q_q[WIDTH-1:1]};
      SHL:     q_d = {q_q[WIDTH-2:0], sin_right_i};
      LOAD:    q_d = d_i;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/usr_serial_seq.sv
// usr_serial_seq: full-duplex serial engine around shift_reg_core; loads a word, shifts L bits out/in.
// Latency: handshake at edge T, bits on ser_out from T+1, rx_valid pulse at T+1+L*CLK_DIV.
// Backpressure: tx_ready_o is high only in IDLE; one transfer in flight, min period L*CLK_DIV+2.
// Ports: clk_i, rst_i (sync active-high); tx_data_i/tx_len_i/tx_lsb_first_i/tx_valid_i/tx_ready_o
//        request handshake; abort_i; ser_in_i/ser_out_o/ser_en_o serial pins; rx_data_o/rx_valid_o
//        received word (right-aligned); busy_o.
module usr_serial_seq
  import usr_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic [LEN_W-1:0] tx_len_i,
  input  logic             tx_lsb_first_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic             abort_i,
  input  logic             ser_in_i,
  output logic             ser_out_o,
  output logic             ser_en_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LEN_W-1:0] bit_q, bit_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             lsb_q, lsb_d;
  logic             ser_en_q, ser_en_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  mode_e            mode;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_shifted;
  logic [WIDTH-1:0] rx_aligned;
  logic [LEN_W-1:0] eff_len;
  logic             tick;
  logic             last_bit;

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mode_i      (mode),
    .d_i         (tx_data_i),
    .sin_left_i  (ser_in_i),
    .sin_right_i (ser_in_i),
    .q_o         (q)
  );

  // Zero and oversize lengths both mean a full-width transfer.
  assign eff_len  = ((tx_len_i == '0) || (tx_len_i > WIDTH_L)) ? WIDTH_L : tx_len_i;
  assign tick     = (div_q == DIV_LAST);
  assign last_bit = (bit_q == (len_q - 1'b1));

  // rx_data is registered on the same edge as the final shift, so align from the
  // value the register is about to take rather than from q itself.
  assign q_shifted  = lsb_q ? {ser_in_i, q[WIDTH-1:1]} : {q[WIDTH-2:0], ser_in_i};
  assign rx_aligned = lsb_q ? (q_shifted >> (WIDTH_L - len_q))
                            : (q_shifted & (ALL_ONES >> (WIDTH_L - len_q)));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    len_d      = len_q;
    lsb_d      = lsb_q;
    ser_en_d   = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    mode       = HOLD;
    case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          mode     = LOAD;
          len_d    = eff_len;
          lsb_d    = tx_lsb_first_i;
          div_d    = '0;
          bit_d    = '0;
          ser_en_d = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          ser_en_d = 1'b1;
          if (tick) begin
            mode  = lsb_q ? SHR : SHL;
            div_d = '0;
            bit_d = bit_q + 1'b1;
            if (last_bit) begin
              state_d    = DONE;
              ser_en_d   = 1'b0;
              rx_valid_d = 1'b1;
              rx_data_d  = rx_aligned;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      len_q      <= '0;
      lsb_q      <= 1'b0;
      ser_en_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      len_q      <= len_d;
      lsb_q      <= lsb_d;
      ser_en_q   <= ser_en_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // ser_out is a pure mux of flops (no input path), gated low outside SHIFT.
  assign ser_out_o  = ser_en_q & (lsb_q ? q[0] : q[WIDTH-1]);
  assign ser_en_o   = ser_en_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_usr_serial_seq.sv
// tb_usr_serial_seq: scoreboard bench for usr_serial_seq at CLK_DIV=1 (dut0) and CLK_DIV=4 (dut1).
// Latency: not applicable.
// Backpressure: the driver waits (bounded) on tx_ready before each request.
module tb_usr_serial_seq;

  localparam int W  = 16;
  localparam int LW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          rst      [2];
  logic [W-1:0]  tx_data  [2];
  logic [LW-1:0] tx_len   [2];
  logic          tx_lsb   [2];
  logic          tx_valid [2];
  logic          abort    [2];
  logic          ser_in   [2];
  logic          tx_ready [2];
  logic          ser_out  [2];
  logic          ser_en   [2];
  logic [W-1:0]  rx_data  [2];
  logic          rx_valid [2];
  logic          busy     [2];

  usr_serial_seq #(.WIDTH(W), .CLK_DIV(1), .LEN_W(LW)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .tx_data_i(tx_data[0]), .tx_len_i(tx_len[0]),
    .tx_lsb_first_i(tx_lsb[0]), .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]),
    .abort_i(abort[0]), .ser_in_i(ser_in[0]), .ser_out_o(ser_out[0]), .ser_en_o(ser_en[0]),
    .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]), .busy_o(busy[0]));

  usr_serial_seq #(.WIDTH(W), .CLK_DIV(4), .LEN_W(LW)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .tx_data_i(tx_data[1]), .tx_len_i(tx_len[1]),
    .tx_lsb_first_i(tx_lsb[1]), .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]),
    .abort_i(abort[1]), .ser_in_i(ser_in[1]), .ser_out_o(ser_out[1]), .ser_en_o(ser_en[1]),
    .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]), .busy_o(busy[1]));

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } rx_exp_t;

  rx_exp_t      rxq  [2][$];
  logic         bitq [2][$];
  logic [W-1:0] hold     [2] = '{default: '0};
  bit           exp_busy [2] = '{default: 1'b0};
  bit           pend_rst [2] = '{default: 1'b0};

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, int s, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h cyc=%0d", name, s, act, req, cyc);
    end
  endfunction

  function automatic int div_of(int s);
    return (s == 0) ? 1 : 4;
  endfunction

  function automatic int eff_len(logic [LW-1:0] len);
    return ((len == 0) || (int'(len) > W)) ? W : int'(len);
  endfunction

  // Monitor: compares every DUT output once per cycle against the scoreboard.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        if (pend_rst[i]) begin
          chk("rst_ser_en",   i, ser_en[i],   0);
          chk("rst_ser_out",  i, ser_out[i],  0);
          chk("rst_rx_valid", i, rx_valid[i], 0);
          chk("rst_rx_data",  i, rx_data[i],  0);
          chk("rst_tx_ready", i, tx_ready[i], 1);
          chk("rst_busy",     i, busy[i],     0);
          hold[i] = '0;
        end
        pend_rst[i] = rst[i];
        if (ser_en[i]) begin
          if (bitq[i].size() == 0) chk("ser_en_unexpected", i, ser_en[i], 0);
          else chk("ser_out", i, ser_out[i], bitq[i].pop_front());
        end else begin
          chk("ser_out_idle", i, ser_out[i], 0);
        end
        if (rx_valid[i]) begin
          if (rxq[i].size() == 0) begin
            chk("rx_valid_unexpected", i, rx_valid[i], 0);
          end else begin
            rx_exp_t e;
            e = rxq[i].pop_front();
            chk("rx_data",  i, rx_data[i], e.data);
            chk("rx_cycle", i, cyc, e.cyc);
            hold[i] = e.data;
          end
          chk("bits_left_at_done", i, bitq[i].size(), 0);
        end
        chk("rx_data_hold", i, rx_data[i], hold[i]);
        chk("busy",     i, busy[i],     exp_busy[i]);
        chk("tx_ready", i, tx_ready[i], !exp_busy[i]);
        if (rx_valid[i]) exp_busy[i] = 1'b0;
      end
    end
  end

  // One request. src: 0 random ser_in per cycle, 1 tied 0, 2 tied 1, 3 loopback of sent bits.
  // abort_at/rst_at: cycle offset after the handshake (1 = first SHIFT cycle), -1 = none.
  task automatic xfer(input int s, input logic [W-1:0] data, input logic [LW-1:0] len,
                      input logic lsb, input int src, input int abort_at, input int rst_at,
                      input bit keep_valid, input bit idle_abort, input int exp_h, output int h);
    int           d, l, n;
    logic         txb [W];
    logic         rxb [W];
    logic [W-1:0] rxv;
    rx_exp_t      e;
    d = div_of(s);
    l = eff_len(len);
    for (int k = 0; k < W; k++) begin
      txb[k] = lsb ? data[k] : data[W-1-k];
      rxb[k] = 1'b0;
    end
    tx_data[s]  = data;
    tx_len[s]   = len;
    tx_lsb[s]   = lsb;
    tx_valid[s] = 1'b1;
    abort[s]    = idle_abort;
    h = -1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready[s] && n < 100);
    if (!tx_ready[s]) begin
      chk("handshake_timeout", s, tx_ready[s], 1);
      tx_valid[s] = 1'b0;
      abort[s]    = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    h = cyc;
    if (exp_h >= 0) chk("b2b_handshake_cycle", s, h, exp_h);
    exp_busy[s] = 1'b1;
    for (int c = 1; c <= l * d; c++) bitq[s].push_back(txb[(c - 1) / d]);
    if (!keep_valid) tx_valid[s] = 1'b0;
    tx_data[s] = W'($urandom);
    tx_len[s]  = LW'($urandom);
    tx_lsb[s]  = 1'($urandom);
    for (int c = 1; c <= l * d; c++) begin
      int k;
      k = (c - 1) / d;
      case (src)
        1:       ser_in[s] = 1'b0;
        2:       ser_in[s] = 1'b1;
        3:       ser_in[s] = txb[k];
        default: ser_in[s] = 1'($urandom);
      endcase
      abort[s] = (c == abort_at);
      rst[s]   = (c == rst_at);
      if (c % d == 0) rxb[k] = ser_in[s];
      @(posedge clk);
      #1;
      if (abort[s] || rst[s]) begin
        abort[s]    = 1'b0;
        rst[s]      = 1'b0;
        tx_valid[s] = 1'b0;
        bitq[s].delete();
        exp_busy[s] = 1'b0;
        return;
      end
    end
    rxv = '0;
    for (int k = 0; k < l; k++) begin
      if (lsb) rxv[k] = rxb[k];
      else     rxv[l-1-k] = rxb[k];
    end
    e.data = rxv;
    e.cyc  = h + l * d;
    rxq[s].push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int h, hp, l, ab, src;
    bit kv, prev_kv;
    logic [LW-1:0] len;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; tx_data[s] = '0; tx_len[s] = '0; tx_lsb[s] = 1'b0;
      tx_valid[s] = 1'b0; abort[s] = 1'b0; ser_in[s] = 1'b0;
    end
    idle(3);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    idle(2);

    // CLK_DIV=1 directed cases
    xfer(0, 16'hA5C3, 5'd16, 1'b0, 3, -1, -1, 1'b0, 1'b0, -1, h);
    idle(2);
    xfer(0, 16'h000B, 5'd4, 1'b1, 2, -1, -1, 1'b0, 1'b0, -1, h);
    idle(2);
    xfer(0, 16'h3C96, 5'd0, 1'b0, 0, -1, -1, 1'b1, 1'b0, -1, hp);
    xfer(0, 16'hE417, 5'd31, 1'b1, 0, -1, -1, 1'b0, 1'b0, hp + 16 + 2, h);
    idle(2);
    xfer(0, 16'h1234, 5'd16, 1'b0, 0, 5, -1, 1'b0, 1'b0, -1, h);
    idle(3);
    xfer(0, 16'hBEEF, 5'd16, 1'b1, 0, -1, 8, 1'b0, 1'b0, -1, h);
    idle(2);
    xfer(0, 16'h5A5A, 5'd9, 1'b0, 3, -1, -1, 1'b0, 1'b1, -1, h);
    idle(2);

    // CLK_DIV=4 directed cases
    xfer(1, 16'h8000, 5'd3, 1'b0, 1, -1, -1, 1'b0, 1'b0, -1, h);
    idle(2);
    xfer(1, 16'hC001, 5'd5, 1'b1, 0, -1, -1, 1'b1, 1'b0, -1, hp);
    xfer(1, 16'h7F3E, 5'd7, 1'b0, 0, -1, -1, 1'b0, 1'b0, hp + 5 * 4 + 2, h);
    idle(2);
    xfer(1, 16'h0FF0, 5'd12, 1'b1, 0, 10, -1, 1'b0, 1'b0, -1, h);
    idle(2);

    // Randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      prev_kv = 1'b0;
      hp = 0;
      l = 0;
      for (int t = 0; t < 30; t++) begin
        int exp_h;
        int lp;
        lp  = l;
        len = LW'($urandom_range(0, 31));
        l   = eff_len(len);
        ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, l * div_of(s))) : -1;
        kv  = (ab < 0) && ($urandom_range(0, 2) == 0);
        src = ($urandom_range(0, 3) == 0) ? 3 : 0;
        exp_h = prev_kv ? hp + lp * div_of(s) + 2 : -1;
        xfer(s, W'($urandom), len, 1'($urandom), src, ab, -1, kv, 1'($urandom_range(0, 3) == 0),
             exp_h, h);
        hp = h;
        prev_kv = kv;
        if (!kv) idle($urandom_range(0, 3));
      end
      tx_valid[s] = 1'b0;
      idle(4);
    end

    idle(70);
    for (int s = 0; s < 2; s++) begin
      chk("rx_queue_drained",  s, rxq[s].size(),  0);
      chk("bit_queue_drained", s, bitq[s].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
